sdr_read_sequencer: RTL and testbench
=====================================

# sdr_read_sequencer

Parametrised SDRAM read sequencer on the `sdr_clk` domain. It sits between the HPS-exported SDRAM bridge (`sdr_readstart`/`sdr_baseaddr`/`sdr_nelems`/`sdr_readdata`/`sdr_readend`) and downstream consumers such as the hex debug display and the ray-tracing core. It turns one start command into as many wide line reads as needed and serialises each line into a valid/ready word stream with backpressure. It generalises the single fixed 2-element read and free-running 32-bit word dump to any line width, word width and transfer length, and adds flow control, an end-of-transfer marker and done/busy status.

## Interface
Parameters:
- `LINE_W`, 2048: width of `sdr_readdata`, in bits.
- `WORD_W`, 32: output word width; `LINE_W % WORD_W == 0`.
- `ADDR_W`, 32: SDRAM byte-address width.
- `NELEMS_W`, 30: width of `sdr_nelems`.
- `REQ_NELEMS`, 2: value driven on `sdr_nelems` for every line request.
- `ADDR_STEP`, `LINE_W/8`: byte increment of `sdr_baseaddr` between consecutive line requests.
- `CNT_W`, 16: width of the word-count input.

Ports:
- `sdr_clk`  in  1  sole clock.
- `sdr_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first line address; sampled with `start`.
- `total_words`  in  CNT_W  number of words to stream; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `sdr_readstart`  out  1  one-cycle read request pulse.
- `sdr_baseaddr`  out  ADDR_W  request address; 0 when not requesting.
- `sdr_nelems`  out  NELEMS_W  `REQ_NELEMS` during a request, 0 otherwise.
- `sdr_readdata`  in  LINE_W  line data; valid in the cycle `sdr_readend`=1.
- `sdr_readend`  in  1  read-complete pulse.
- `out_data`  out  WORD_W  current word.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_last`  out  1  qualifies the final word of the transfer.

## Operation
- Derived constant: WPL = `LINE_W/WORD_W` words per line.
- States:
  - IDLE: on `start`, latch `base_addr` and `total_words` and clear the word index.
    - `total_words`==0: go to FIN; no SDRAM request is issued.
    - Otherwise: go to REQ.
  - REQ: drive `sdr_readstart`=1, `sdr_baseaddr`=current address, `sdr_nelems`=`REQ_NELEMS` for exactly one cycle; go to WAIT.
  - WAIT: on `sdr_readend`, capture `sdr_readdata` into the line register; go to STREAM.
  - STREAM: `out_data` = line[WORD_W*idx +: WORD_W], with idx starting at 0 (word 0 is the LSBs).
    - On each `out_valid & out_ready`: decrement remaining and increment idx.
    - If remaining reaches 0: go to FIN.
    - Else if idx reaches WPL: address += `ADDR_STEP` (modulo 2^ADDR_W), idx = 0, go to REQ.
  - FIN: `done`=1 for one cycle; go to IDLE.
- `out_last` = `out_valid` & (remaining==1).
- A partial final line streams only the remaining words; the rest of that line is discarded.
- `start` outside IDLE is ignored. `sdr_readend` outside WAIT is ignored.
- `sdr_reset` in any state: return to IDLE the next edge and abandon any in-flight SDRAM read. A `sdr_readend` from the abandoned read is ignored because the block is no longer in WAIT.

## Timing
- Reset values: `busy`, `done`, `sdr_readstart`, `out_valid`, `out_last` = 0; `sdr_baseaddr`, `sdr_nelems`, `out_data` = 0.
- Start latency: `start` at cycle t → `sdr_readstart` at t+1, `busy`=1 from t+1.
- Read-to-stream: `sdr_readend` at cycle r → `out_valid`=1 with word 0 at r+1.
- Throughput: one word per cycle while `out_ready`=1. `out_data`/`out_valid` are registered and hold stable while `out_valid & !out_ready`.
- Line boundary: last word of a line accepted at cycle c (remaining>0) → `out_valid`=0 and next `sdr_readstart` at c+1.
- Completion: last word accepted at c → `done`=1 and `busy`=0 at c+1. Zero-length transfer: `start` at t → `done` at t+2, `busy` high only at t+1.
- `done` and `start` in the same cycle: `start` is ignored (the block is in FIN, not IDLE).

## Structure
- Package `sdr_seq_pkg`: state enum `sdr_seq_state_t` {IDLE, REQ, WAIT, STREAM, FIN}.
- One sub-module, `sdr_line_serializer`: holds the line register and the idx counter, and drives `out_data`. The parent FSM drives its load and advance inputs.

## Test plan
- Parameters `LINE_W`=2048, `WORD_W`=32, `total_words`=5, `base_addr`=0x100, `out_ready`=1: expect one request (addr 0x100, nelems 2), then words 0..4 of the line on consecutive cycles, `out_last` on word 4, `done` the next cycle.
- `total_words`=130 (WPL=64): expect three requests at 0x0, 0x100, 0x200, all 64 words of lines 0 and 1, then 2 words of line 2.
- Random `out_ready` backpressure: `out_data` stable while stalled; the consumer receives an exact in-order copy with no drops or duplicates.
- `total_words`=0: no `sdr_readstart`, `done` 2 cycles after `start`. A second `start` while busy: ignored, no extra request.
- `sdr_reset` asserted in WAIT, then a late `sdr_readend`: outputs at reset values, `out_valid` stays 0. A fresh `start` then completes normally.
- `base_addr`=0xFFFFFF00 with 2 lines: second request address wraps to 0x00000000.

Source files
------------

// File: rtl/sdr_seq_pkg.sv
// sdr_seq_pkg: shared FSM state type for the SDRAM read sequencer.
package sdr_seq_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, FIN} sdr_seq_state_t;
endpackage

// File: rtl/sdr_line_serializer.sv
// sdr_line_serializer: holds one SDRAM line and presents it word by word, word 0 in the LSBs.
module sdr_line_serializer #(
    parameter int LINE_W = 2048,
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              adv_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o
);
    localparam int WPL = LINE_W / WORD_W;
    localparam int IDX_W = WPL > 1 ? $clog2(WPL) : 1;
    logic [LINE_W-1:0] line_q;
    logic [IDX_W-1:0]  idx_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
            idx_q  <= '0;
        end else begin
            if (load_i) line_q <= line_i;
            if (load_i || clr_i) idx_q <= '0;
            else if (adv_i) idx_q <= last_o ? '0 : idx_q + 1'b1;
        end
    end
    assign last_o = idx_q == IDX_W'(WPL - 1);
    assign word_o = line_q[idx_q*WORD_W +: WORD_W];
endmodule

// File: rtl/sdr_read_sequencer.sv
// sdr_read_sequencer: turns one start command into line reads from the SDRAM bridge
// and streams the words out over valid/ready with an end-of-transfer marker.
module sdr_read_sequencer
    import sdr_seq_pkg::*;
#(
    parameter int LINE_W     = 2048,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int NELEMS_W   = 30,
    parameter int REQ_NELEMS = 2,
    parameter int ADDR_STEP  = LINE_W / 8,
    parameter int CNT_W      = 16
) (
    input  logic                sdr_clk,
    input  logic                sdr_reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    total_words,
    output logic                busy,
    output logic                done,
    output logic                sdr_readstart,
    output logic [ADDR_W-1:0]   sdr_baseaddr,
    output logic [NELEMS_W-1:0] sdr_nelems,
    input  logic [LINE_W-1:0]   sdr_readdata,
    input  logic                sdr_readend,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);
    sdr_seq_state_t      state_q;
    logic [ADDR_W-1:0]   addr_q, addr_step, ba_q;
    logic [CNT_W-1:0]    rem_q;
    logic [NELEMS_W-1:0] ne_q;
    logic                busy_q, done_q, rs_q, valid_q;
    logic                clr, load, adv, line_end;
    assign addr_step = addr_q + ADDR_W'(ADDR_STEP);
    assign clr  = state_q == IDLE && start;
    assign load = state_q == WAIT && sdr_readend;
    assign adv  = state_q == STREAM && valid_q && out_ready;
    sdr_line_serializer #(.LINE_W(LINE_W), .WORD_W(WORD_W)) u_ser (
        .clk_i(sdr_clk), .rst_i(sdr_reset), .clr_i(clr), .load_i(load),
        .line_i(sdr_readdata), .adv_i(adv), .word_o(out_data), .last_o(line_end)
    );
    always_ff @(posedge sdr_clk) begin
        if (sdr_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            ba_q    <= '0;
            ne_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    addr_q <= base_addr;
                    rem_q  <= total_words;
                    busy_q <= 1'b1;
                    if (total_words == '0) state_q <= FIN;
                    else begin
                        state_q <= REQ;
                        rs_q    <= 1'b1;
                        ba_q    <= base_addr;
                        ne_q    <= NELEMS_W'(REQ_NELEMS);
                    end
                end
                REQ: begin
                    rs_q    <= 1'b0;
                    ba_q    <= '0;
                    ne_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (sdr_readend) begin
                    valid_q <= 1'b1;
                    state_q <= STREAM;
                end
                STREAM: if (adv) begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end else if (line_end) begin
                        valid_q <= 1'b0;
                        addr_q  <= addr_step;
                        rs_q    <= 1'b1;
                        ba_q    <= addr_step;
                        ne_q    <= NELEMS_W'(REQ_NELEMS);
                        state_q <= REQ;
                    end
                end
                // a zero-length transfer arrives here with done low and spends one extra cycle raising it
                FIN: if (done_q) begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy          = busy_q;
    assign done          = done_q;
    assign sdr_readstart = rs_q;
    assign sdr_baseaddr  = ba_q;
    assign sdr_nelems    = ne_q;
    assign out_valid     = valid_q;
    assign out_last      = valid_q && rem_q == CNT_W'(1);
endmodule

// File: tb/tb_sdr_read_sequencer.sv
// tb_sdr_read_sequencer: randomized transfers against an SDRAM responder and a word-stream reference model.
module tb_sdr_read_sequencer;
    localparam int LINE_W = 2048;
    localparam int WORD_W = 32;
    localparam int WPL    = LINE_W / WORD_W;
    logic          sdr_clk = 1'b0;
    logic          sdr_reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [15:0]   total_words = '0;
    logic          busy, done, sdr_readstart, out_valid, out_last;
    logic [31:0]   sdr_baseaddr, out_data;
    logic [29:0]   sdr_nelems;
    logic [2047:0] sdr_readdata = '0;
    logic          sdr_readend = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   salt = 32'h1234_5678;
    int            n_pass = 0;
    int            n_chk = 0;

    always #5 sdr_clk = ~sdr_clk;

    sdr_read_sequencer #(
        .LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(32), .NELEMS_W(30),
        .REQ_NELEMS(2), .ADDR_STEP(LINE_W / 8), .CNT_W(16)
    ) dut (
        .sdr_clk(sdr_clk), .sdr_reset(sdr_reset), .start(start), .base_addr(base_addr),
        .total_words(total_words), .busy(busy), .done(done), .sdr_readstart(sdr_readstart),
        .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_readdata(sdr_readdata),
        .sdr_readend(sdr_readend), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    // SDRAM content: word k of the line at byte address a
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
        return a ^ (32'(k) * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [2047:0] mem_line(input logic [31:0] a);
        logic [2047:0] l;
        for (int k = 0; k < WPL; k++) l[k*WORD_W +: WORD_W] = mem_word(a, k);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rs"}, sdr_readstart, 0);
        chk({tag, "_addr"}, sdr_baseaddr, 0);
        chk({tag, "_nelems"}, sdr_nelems, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    // one complete transfer; the expected stream is line i = base + i*256, word k of it
    task automatic run(input logic [31:0] base, input int n, input int rdy_pct, input bit spurious);
        int nreq = (n + WPL - 1) / WPL;
        int got = 0, reqs = 0, cyc = 0, dly = 0;
        bit pend = 0, fin = 0, exp_req = 1, exp_v = 0, exp_gap = 0, exp_done = 0, stall = 0;
        logic [31:0] req_a = '0, held = '0, ea;
        salt = $urandom;
        @(negedge sdr_clk);
        start = 1; base_addr = base; total_words = 16'(n);
        @(negedge sdr_clk);
        start = 0; base_addr = $urandom; total_words = 16'($urandom);
        while (!fin && cyc < 5000) begin
            sdr_readend = 0;
            if (exp_req) chk("req_timing", sdr_readstart, 1);
            if (exp_v) chk("valid_timing", out_valid, 1);
            if (exp_gap) chk("line_gap", out_valid, 0);
            exp_req = 0; exp_v = 0; exp_gap = 0;
            if (exp_done) begin
                chk("done", done, 1);
                chk("busy_end", busy, 0);
                chk("word_count", got, n);
                chk("req_count", reqs, nreq);
                fin = 1;
                break;
            end
            chk("busy", busy, 1);
            if (done) chk("early_done", done, 0);
            if (sdr_readstart) begin
                ea = base + 32'(reqs * 256);
                chk("req_addr", sdr_baseaddr, ea);
                chk("req_nelems", sdr_nelems, 2);
                reqs++;
                pend = 1; req_a = sdr_baseaddr; dly = $urandom_range(0, 3);
            end else if (pend) begin
                if (dly == 0) begin
                    sdr_readend = 1; sdr_readdata = mem_line(req_a); pend = 0; exp_v = 1;
                end else dly--;
            end
            if (!out_valid) chk("last_idle", out_last, 0);
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
            end
            out_ready = $urandom_range(0, 99) < rdy_pct;
            start = spurious && cyc == 4;
            if (out_valid && out_ready) begin
                ea = base + 32'((got / WPL) * 256);
                chk("data", out_data, mem_word(ea, got % WPL));
                chk("last", out_last, got == n - 1);
                got++;
                if (got == n) exp_done = 1;
                else if (got % WPL == 0) begin exp_req = 1; exp_gap = 1; end
                else if (rdy_pct == 100) exp_v = 1;
                stall = 0;
            end else begin
                stall = out_valid; held = out_data;
            end
            cyc++;
            @(negedge sdr_clk);
        end
        chk("timeout", fin, 1);
        sdr_readend = 0; start = 0; out_ready = 0;
        @(negedge sdr_clk);
        chk("done_pulse", done, 0);
        chk("idle_rs", sdr_readstart, 0);
    endtask

    initial begin
        repeat (3) @(negedge sdr_clk);
        chk_idle("reset");
        chk("reset_data", out_data, 0);
        sdr_reset = 0;
        @(negedge sdr_clk);
        chk_idle("post_reset");
        run(32'h0000_0100, 5, 100, 0);
        run(32'h0000_0000, 130, 100, 1);
        for (int i = 0; i < 6; i++) run($urandom, $urandom_range(1, 200), 50, i == 0);
        run(32'hFFFF_FF00, 100, 100, 0);
        // zero-length transfer with starts while busy and during done
        @(negedge sdr_clk);
        start = 1; base_addr = 32'h200; total_words = 0;
        @(negedge sdr_clk);
        start = 1; total_words = 5;
        chk("zl_busy", busy, 1);
        chk("zl_done_early", done, 0);
        chk("zl_rs", sdr_readstart, 0);
        @(negedge sdr_clk);
        chk("zl_done", done, 1);
        chk("zl_busy_end", busy, 0);
        chk("zl_rs2", sdr_readstart, 0);
        @(negedge sdr_clk);
        start = 0;
        chk_idle("zl_after");
        @(negedge sdr_clk);
        chk_idle("zl_after2");
        // reset while waiting on SDRAM, then a stale readend
        @(negedge sdr_clk);
        start = 1; base_addr = 32'h40; total_words = 10;
        @(negedge sdr_clk);
        start = 0;
        chk("rst_req", sdr_readstart, 1);
        @(negedge sdr_clk);
        sdr_reset = 1;
        @(negedge sdr_clk);
        sdr_reset = 0;
        sdr_readend = 1; sdr_readdata = mem_line(32'h40); out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sdr_clk);
            sdr_readend = 0;
            chk_idle("rst_wait");
            chk("rst_data", out_data, 0);
        end
        out_ready = 0;
        run(32'h0000_0040, 70, 70, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
